rv32_uart_tx_mmio: RTL



---
 rtl/rv32_uart_tx_mmio.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/rv32_uart_tx_mmio.sv
// rv32_uart_tx_mmio: memory-mapped UART transmitter with TX FIFO on the RAM-style bus.
// Build option UART_PARITY_EN adds an even-parity bit (8E1 frames, STATUS[4]=1).
module rv32_uart_tx_mmio #(
    parameter int unsigned           ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_WADDR = 16'hFF00,
    parameter int unsigned           FIFO_DEPTH = 8,
    parameter logic [15:0]           DIV_RESET  = 16'd868
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  bus_wr_en,
    input  logic [3:0]            bus_wr_strobe,
    input  logic [ADDR_WIDTH-1:0] bus_addr,
    input  logic [31:0]           bus_wr_data,
    output logic [31:0]           rd_data,
    output logic                  rd_hit,
    output logic                  tx,
    output logic                  irq
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = PW + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_q, par_d;
    logic            tx_q, tx_d;
    logic            irq_q, irq_d;
    logic [LW-1:0]   level_q, level_d;
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic            ovf_q, ovf_d;
    logic [15:0]     div_q, div_d;
    logic [31:0]     rd_data_q, rd_data_d;
    logic            rd_hit_q, rd_hit_d;
    logic [7:0]      mem_q [FIFO_DEPTH];

    logic            hit, wr_hit, push, push_ok, pop, empty, full, bit_end;
    logic [1:0]      off;
    logic [15:0]     div_eff;
    logic [31:0]     status;
    logic            unused_bits;

    assign unused_bits = ^{bus_wr_data[31:16], bus_wr_strobe[3:2]};

    always_comb begin
        hit     = bus_addr[ADDR_WIDTH-1:2] == BASE_WADDR[ADDR_WIDTH-1:2];
        off     = bus_addr[1:0];
        wr_hit  = bus_wr_en && hit;
        push    = wr_hit && (off == 2'd0) && bus_wr_strobe[0];
        empty   = level_q == '0;
        full    = level_q == LW'(FIFO_DEPTH);
        div_eff = (div_q == 16'd0) ? 16'd1 : div_q;
        bit_end = cnt_q == 16'd0;
    end

    // Serializer; a frame ending with data queued chains straight into START.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        pop     = 1'b0;
        if (state_q != S_IDLE) begin
            cnt_d = bit_end ? div_eff - 16'd1 : cnt_q - 16'd1;
        end
        unique case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rptr_q];
                    par_d   = ^mem_q[rptr_q];
                    cnt_d   = div_eff - 16'd1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) state_d = S_STOP;
            end
            S_STOP: begin
                if (bit_end) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rptr_q];
                        par_d   = ^mem_q[rptr_q];
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
    end

    // A pop on a full FIFO frees the slot the same-cycle push lands in.
    always_comb begin
        push_ok = push && (!full || pop);
        level_d = level_q + LW'(push_ok) - LW'(pop);
        wptr_d  = push_ok ? wptr_q + PW'(1) : wptr_q;
        rptr_d  = pop ? rptr_q + PW'(1) : rptr_q;
        ovf_d   = ovf_q;
        if (wr_hit && off == 2'd1 && bus_wr_strobe[0] && bus_wr_data[3]) begin
            ovf_d = 1'b0;
        end
        if (push && !push_ok) ovf_d = 1'b1;
        div_d = div_q;
        if (wr_hit && off == 2'd2) begin
            if (bus_wr_strobe[0]) div_d[7:0]  = bus_wr_data[7:0];
            if (bus_wr_strobe[1]) div_d[15:8] = bus_wr_data[15:8];
        end
        irq_d = (level_d == '0) && (state_d == S_IDLE);
    end

    always_comb begin
        status       = '0;
        status[0]    = full;
        status[1]    = empty;
        status[2]    = state_q != S_IDLE;
        status[3]    = ovf_q;
        status[15:8] = 8'(level_q);
`ifdef UART_PARITY_EN
        status[4]    = 1'b1;
`else
        status[4]    = 1'b0;
`endif
        rd_hit_d  = hit;
        rd_data_d = '0;
        if (hit) begin
            case (off)
                2'd1:    rd_data_d = status;
                2'd2:    rd_data_d = {16'h0, div_q};
                default: rd_data_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            tx_q      <= 1'b1;
            irq_q     <= 1'b1;
            level_q   <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            ovf_q     <= 1'b0;
            div_q     <= DIV_RESET;
            rd_data_q <= '0;
            rd_hit_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            tx_q      <= tx_d;
            irq_q     <= irq_d;
            level_q   <= level_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            ovf_q     <= ovf_d;
            div_q     <= div_d;
            rd_data_q <= rd_data_d;
            rd_hit_q  <= rd_hit_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= bus_wr_data[7:0];
    end

    assign rd_data = rd_data_q;
    assign rd_hit  = rd_hit_q;
    assign tx      = tx_q;
    assign irq     = irq_q;
endmodule
